ramteste_s2_mailbox: RTL

// Fabric-side master for port s2 of the ramteste dual-port on-chip RAM.
// The HPS uses port s1 to write a command word and two operands. This block polls the

---
 rtl/ramteste_s2_mailbox_if.sv | 28 ++
 rtl/ramteste_s2_mailbox.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/ramteste_s2_mailbox_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ramteste_s2_mailbox_if                                          |
// | Brief    : Avalon-MM style port s2 bundle of the ramteste dual-port RAM.   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
interface ramteste_s2_mailbox_if;
    logic [1:0]  ram_address;
    logic        ram_chipselect;
    logic        ram_clken;
    logic        ram_write;
    logic [31:0] ram_writedata;
    logic [3:0]  ram_byteenable;
    logic [31:0] ram_readdata;

    modport master (
        output ram_address, ram_chipselect, ram_clken, ram_write,
               ram_writedata, ram_byteenable,
        input  ram_readdata
    );

    modport slave (
        input  ram_address, ram_chipselect, ram_clken, ram_write,
               ram_writedata, ram_byteenable,
        output ram_readdata
    );
endinterface
`default_nettype wire

// File: rtl/ramteste_s2_mailbox.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ramteste_s2_mailbox                                             |
// | Brief    : Polls a RAM mailbox on port s2, runs a 32-bit op, writes back.  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module ramteste_s2_mailbox #(
    parameter int POLL_INTERVAL = 64,
    parameter int READ_LATENCY  = 1
) (
    input  logic                         clk_clk,
    input  logic                         reset_reset_n,
    input  logic                         enable,
    ramteste_s2_mailbox_if.master        ram,
    output logic                         busy,
    output logic                         done_pulse,
    output logic [15:0]                  op_count
);

    localparam int               c_CNT_W    = $clog2(POLL_INTERVAL + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_INIT = c_CNT_W'(POLL_INTERVAL);
    localparam logic [1:0]       c_RL       = 2'(READ_LATENCY);

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_RD_CTRL = 3'd1;
    localparam logic [2:0] c_WR_BUSY = 3'd2;
    localparam logic [2:0] c_RD_A    = 3'd3;
    localparam logic [2:0] c_RD_B    = 3'd4;
    localparam logic [2:0] c_EXEC    = 3'd5;
    localparam logic [2:0] c_WR_RES  = 3'd6;
    localparam logic [2:0] c_WR_DONE = 3'd7;

    logic [2:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [1:0]         r_wait;
    logic [7:0]         r_opcode;
    logic [31:0]        r_a;
    logic [31:0]        r_b;
    logic               r_err;
    logic [1:0]         r_address;
    logic               r_cs;
    logic               r_write;
    logic [31:0]        r_wdata;
    logic [3:0]         r_be;
    logic               r_busy;
    logic               r_done;
    logic [15:0]        r_op_count;

    logic [31:0] w_sum;
    logic [31:0] w_diff;
    logic [31:0] w_prod;
    logic [31:0] w_sat;
    logic        w_ovf;
    logic [31:0] w_result;
    logic        w_err;
    logic        w_rd_valid;

    assign w_sum  = r_a + r_b;
    assign w_diff = r_a - r_b;
    // Low 32 bits of a product are the same for signed and unsigned operands.
    assign w_prod = r_a * r_b;
    assign w_ovf  = (r_a[31] == r_b[31]) && (w_sum[31] != r_a[31]);
    assign w_sat  = w_ovf ? (r_a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF) : w_sum;

    always_comb begin
        w_result = 32'h0;
        w_err    = 1'b0;
        case (r_opcode)
            8'h00:   w_result = w_sum;
            8'h01:   w_result = w_diff;
            8'h02:   w_result = w_prod;
            8'h03:   w_result = w_sat;
            default: w_err    = 1'b1;
        endcase
    end

    assign w_rd_valid = (r_wait == c_RL);

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            r_state    <= c_IDLE;
            r_cnt      <= c_CNT_INIT;
            r_wait     <= 2'd0;
            r_opcode   <= 8'h0;
            r_a        <= 32'h0;
            r_b        <= 32'h0;
            r_err      <= 1'b0;
            r_address  <= 2'd0;
            r_cs       <= 1'b0;
            r_write    <= 1'b0;
            r_wdata    <= 32'h0;
            r_be       <= 4'h0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_op_count <= 16'h0;
        end else begin
            // Every access lasts exactly one cycle unless re-issued below.
            r_cs    <= 1'b0;
            r_write <= 1'b0;
            r_be    <= 4'h0;
            r_done  <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (enable) begin
                        if (r_cnt == '0) begin
                            r_state   <= c_RD_CTRL;
                            r_cs      <= 1'b1;
                            r_be      <= 4'hF;
                            r_address <= 2'd0;
                            r_wait    <= 2'd0;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                end
                c_RD_CTRL: begin
                    r_wait <= r_wait + 2'd1;
                    if (w_rd_valid) begin
                        // A set BUSY flag means a stale aborted op: never restart it.
                        if (ram.ram_readdata[0] && !ram.ram_readdata[1]) begin
                            r_opcode  <= ram.ram_readdata[15:8];
                            r_state   <= c_WR_BUSY;
                            r_busy    <= 1'b1;
                            r_cs      <= 1'b1;
                            r_write   <= 1'b1;
                            r_be      <= 4'hF;
                            r_address <= 2'd0;
                            r_wdata   <= {16'h0, ram.ram_readdata[15:8], 8'h03};
                        end else begin
                            r_cnt   <= c_CNT_INIT;
                            r_state <= c_IDLE;
                        end
                    end
                end
                c_WR_BUSY: begin
                    r_state   <= c_RD_A;
                    r_cs      <= 1'b1;
                    r_be      <= 4'hF;
                    r_address <= 2'd1;
                    r_wait    <= 2'd0;
                end
                c_RD_A: begin
                    r_wait <= r_wait + 2'd1;
                    if (w_rd_valid) begin
                        r_a       <= ram.ram_readdata;
                        r_state   <= c_RD_B;
                        r_cs      <= 1'b1;
                        r_be      <= 4'hF;
                        r_address <= 2'd2;
                        r_wait    <= 2'd0;
                    end
                end
                c_RD_B: begin
                    r_wait <= r_wait + 2'd1;
                    if (w_rd_valid) begin
                        r_b     <= ram.ram_readdata;
                        r_state <= c_EXEC;
                    end
                end
                c_EXEC: begin
                    r_err     <= w_err;
                    r_state   <= c_WR_RES;
                    r_cs      <= 1'b1;
                    r_write   <= 1'b1;
                    r_be      <= 4'hF;
                    r_address <= 2'd3;
                    r_wdata   <= w_result;
                end
                c_WR_RES: begin
                    r_state    <= c_WR_DONE;
                    r_cs       <= 1'b1;
                    r_write    <= 1'b1;
                    r_be       <= 4'hF;
                    r_address  <= 2'd0;
                    r_wdata    <= {16'h0, r_opcode, 4'h0, r_err, 3'b100};
                    r_done     <= 1'b1;
                    r_op_count <= r_op_count + 16'd1;
                end
                c_WR_DONE: begin
                    r_busy  <= 1'b0;
                    r_cnt   <= c_CNT_INIT;
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign ram.ram_address    = r_address;
    assign ram.ram_chipselect = r_cs;
    assign ram.ram_clken      = 1'b1;
    assign ram.ram_write      = r_write;
    assign ram.ram_writedata  = r_wdata;
    assign ram.ram_byteenable = r_be;
    assign busy               = r_busy;
    assign done_pulse         = r_done;
    assign op_count           = r_op_count;

endmodule
`default_nettype wire
